// File: rtl/um_fetch_unit.sv
// Fetch stage: reads the UM program word at pc from the zero array over the shared mem bus and hands it to decode.
// Latency: grant seen in FETCH at cycle N -> inst_valid from cycle N+2; one instruction per 3 cycles at best.
// Backpressure: the word waits in HOLD until inst_ready; no new bus request is raised while a word is held.
module um_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] ZERO_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic        bus_en,
  output logic [2:0]  bus_mode,
  output logic [31:0] bus_address,
  output logic [31:0] bus_offset,
  output logic [31:0] bus_data,
  input  logic [31:0] mem_data_out,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [2:0] MODE_READ = 3'b000;
  localparam logic [2:0] MODE_NOP  = 3'b100;

  // FETCH: requesting the bus; WAIT: read issued, data arrives this cycle;
  // HOLD: word presented to decode; HALTED: idle until redirect or reset.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        handshake;

  // A word is consumed only when it is actually being offered.
  assign handshake = inst_valid && inst_ready;

  // Bus request and drive values; a redirect or halt cycle never issues a read.
  always_comb begin
    bus_req     = (state == ST_FETCH) && !redirect_valid && !halt;
    bus_en      = bus_req && bus_grant;
    bus_data    = 32'h0;
    bus_mode    = MODE_NOP;
    bus_address = 32'h0;
    bus_offset  = 32'h0;
    if (bus_en) begin
      bus_mode    = MODE_READ;
      bus_address = ZERO_ADDR;
      bus_offset  = pc;
    end
  end

  // Fetch sequencing with priority reset > halt > redirect > normal flow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      inst        <= 32'h0;
      inst_pc     <= 32'h0;
      inst_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      // An accepted word counts even if halt/redirect steer the next state.
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (halt && (state != ST_HALTED)) begin
        // Any read in flight is abandoned; pc stays where it was.
        state      <= ST_HALTED;
        inst_valid <= 1'b0;
        halted     <= 1'b1;
      end else if (redirect_valid) begin
        // Also the only way out of HALTED; a WAIT read is dropped.
        state      <= ST_FETCH;
        pc         <= redirect_pc;
        inst_valid <= 1'b0;
        halted     <= 1'b0;
      end else begin
        case (state)
          ST_FETCH: begin
            if (bus_en) begin
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // Memory registers read data, so the word for pc is on mem_data_out now.
            inst       <= mem_data_out;
            inst_pc    <= pc;
            pc         <= pc + 32'd1;
            inst_valid <= 1'b1;
            state      <= ST_HOLD;
          end
          ST_HOLD: begin
            if (handshake) begin
              inst_valid <= 1'b0;
              state      <= ST_FETCH;
            end
          end
          ST_HALTED: begin
            state <= ST_HALTED;
          end
          default: begin
            state <= ST_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_um_fetch_unit.sv
// Bench for um_fetch_unit: transaction-level model plus directed literal checks and a randomized phase.
module tb_um_fetch_unit;

  logic        clk;
  logic        reset;
  logic        bus_req;
  logic        bus_grant;
  logic        bus_en;
  logic [2:0]  bus_mode;
  logic [31:0] bus_address;
  logic [31:0] bus_offset;
  logic [31:0] bus_data;
  logic [31:0] mem_data_out;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  um_fetch_unit #(.RESET_PC(32'h0), .ZERO_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_en(bus_en),
    .bus_mode(bus_mode), .bus_address(bus_address), .bus_offset(bus_offset),
    .bus_data(bus_data), .mem_data_out(mem_data_out),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-array contents: 0..2 hold A,B,C; everything else a scrambled value of the offset.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a < 32'd3) return 32'hA + a;
    return (a * 32'h9E3779B1) ^ 32'hC3D2E1F0;
  endfunction

  // Memory: registered read on mode 000; garbage otherwise so stale data is never usable.
  always @(posedge clk) begin
    if (bus_en && bus_mode == 3'b000) mem_data_out <= word(bus_offset);
    else mem_data_out <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fetcher described by flags: stopped, a read outstanding, a word on offer.
  logic        model_on = 1'b0;
  logic        m_halted, m_pending, m_offer;
  logic [31:0] m_pc, m_inst, m_inst_pc, m_count;

  always @(negedge clk) begin
    logic want, grant_now, accepted;
    want      = !m_halted && !m_pending && !m_offer && !redirect_valid && !halt;
    grant_now = want && bus_grant;
    if (model_on) begin
      chk("bus_req", 32'(bus_req), 32'(want));
      chk("bus_en", 32'(bus_en), 32'(grant_now));
      chk("bus_mode", 32'(bus_mode), grant_now ? 32'd0 : 32'd4);
      chk("bus_address", bus_address, 32'h0);
      chk("bus_offset", bus_offset, grant_now ? m_pc : 32'h0);
      chk("bus_data", bus_data, 32'h0);
      chk("inst_valid", 32'(inst_valid), 32'(m_offer));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fetch_count", fetch_count, m_count);
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
    end
    if (!reset) begin
      model_on  = 1'b1;
      m_halted  = 1'b0; m_pending = 1'b0; m_offer = 1'b0;
      m_pc      = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0; m_count = 32'h0;
    end else if (model_on) begin
      accepted = m_offer && inst_ready;
      if (accepted) m_count = m_count + 1;
      if (halt && !m_halted) begin
        m_halted = 1'b1; m_offer = 1'b0; m_pending = 1'b0;
      end else if (redirect_valid) begin
        m_halted = 1'b0; m_offer = 1'b0; m_pending = 1'b0; m_pc = redirect_pc;
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_pending) begin
        m_inst = word(m_pc); m_inst_pc = m_pc; m_pc = m_pc + 1;
        m_offer = 1'b1; m_pending = 1'b0;
      end else if (m_offer) begin
        if (accepted) m_offer = 1'b0;
      end else if (grant_now) begin
        m_pending = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) at negedges until inst_valid is seen.
  task automatic wait_valid(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (inst_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL %s timeout actual=no_valid expected=valid", name); end
  endtask

  initial begin
    logic        ok;
    int          first_valid;
    logic [31:0] q_inst[$];
    logic [31:0] q_pc[$];
    logic [31:0] ev;

    reset = 1'b0; bus_grant = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    mem_data_out = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; bus_grant = 1'b1; inst_ready = 1'b1;

    // Directed: first three words, latency and count.
    first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("reset_inst_valid", 32'(inst_valid), 32'h0);
      if (inst_valid && first_valid < 0) first_valid = i;
      if (inst_valid && inst_ready) begin q_inst.push_back(inst); q_pc.push_back(inst_pc); end
      if (i == 9) chk("count_after_3", fetch_count, 32'd3);
    end
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("num_delivered", 32'(q_inst.size()), 32'd3);
    for (int k = 0; k < 3 && k < q_inst.size(); k++) begin
      ev = 32'hA + 32'(k);
      chk("dir_inst", q_inst[k], ev);
      chk("dir_inst_pc", q_pc[k], 32'(k));
    end

    // Directed: redirect to the top of the address space, then wrap.
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); redirect_valid = 1'b0;
    wait_valid("wrap_wait", ok);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFF);
    chk("wrap_inst", inst, (32'hFFFF_FFFF * 32'h9E3779B1) ^ 32'hC3D2E1F0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_en) begin chk("wrap_next_offset", bus_offset, 32'h0); ok = 1'b1; break; end
    end
    chk("wrap_next_seen", 32'(ok), 32'h1);

    // Directed: halt, then restart at 5; halt+redirect together stays halted.
    step(); halt = 1'b1;
    @(negedge clk); chk("halt_no_req", 32'(bus_req), 32'h0);
    step(); halt = 1'b0;
    @(negedge clk);
    chk("halted_set", 32'(halted), 32'h1);
    chk("halted_no_valid", 32'(inst_valid), 32'h0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'd5;
    step(); redirect_valid = 1'b0;
    wait_valid("restart_wait", ok);
    chk("restart_inst_pc", inst_pc, 32'd5);
    step(); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd9;
    step(); halt = 1'b0; redirect_valid = 1'b0;
    @(negedge clk); chk("halt_beats_redirect", 32'(halted), 32'h1);
    step(); redirect_valid = 1'b1; redirect_pc = 32'd0;
    step(); redirect_valid = 1'b0;

    // Randomized phase: the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      step();
      reset          = ($urandom_range(0, 199) != 0);
      bus_grant      = ($urandom_range(0, 99) < 70);
      inst_ready     = ($urandom_range(0, 99) < 60);
      halt           = ($urandom_range(0, 99) < 3);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0: redirect_pc = 32'hFFFF_FFFF;
        1: redirect_pc = $urandom;
        default: redirect_pc = 32'($urandom_range(0, 64));
      endcase
    end
    step();
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/um_fetch_unit.md
Name: um_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the memory system.
- Holds the UM execution finger (pc) and reads each instruction from the zero array with a mem-bus read: mode 000, address 0, offset pc.
- Presents fetched words to decode over a valid/ready handshake.
- Shares the mem bus with execute through an external arbiter (bus_req/bus_grant); supports redirect (load program) and halt.

Parameters:
- RESET_PC, 32'h0, pc value loaded on reset.
- ZERO_ADDR, 32'h0, address field driven on fetch; the memory system maps address 0 onto the current zero array.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
- bus_req  output  1  request for the shared mem bus.
- bus_grant  input  1  arbiter grant, valid in the same cycle as bus_req.
- bus_en  output  1  tristate enable for this block's mem_in_bus drivers.
- bus_mode  output  3  mem bus mode: 000 read, 100 no-op.
- bus_address  output  32  mem bus address field.
- bus_offset  output  32  mem bus offset field.
- bus_data  output  32  mem bus data field; always 0.
- mem_data_out  input  32  registered read data from the memory system.
- inst  output  32  fetched instruction word.
- inst_pc  output  32  pc of inst.
- inst_valid  output  1  inst/inst_pc valid.
- inst_ready  input  1  decode accepts inst.
- redirect_valid  input  1  load-program jump request.
- redirect_pc  input  32  new pc.
- halt  input  1  stop fetching.
- halted  output  1  block is in HALTED.
- fetch_count  output  32  count of instructions delivered to decode (handshakes).

Behaviour:
- States: FETCH, WAIT, HOLD, HALTED.
- Reset (reset==0 at posedge): state=FETCH, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fetch_count=0, halted=0. Reset overrides all inputs, including mid-WAIT (the returning word is dropped).
- Combinational bus outputs:
  - bus_req = (state==FETCH) && !redirect_valid && !halt.
  - bus_en = bus_req && bus_grant.
  - When bus_en: bus_mode=000, bus_address=ZERO_ADDR, bus_offset=pc.
  - Otherwise: bus_mode=100, bus_address=0, bus_offset=0.
  - bus_data is always 0.
- Input priority each cycle: reset > halt > redirect_valid > normal operation.
- halt=1 (any state): next state HALTED, inst_valid<=0, any in-flight read discarded, pc unchanged.
  - HALTED: halted=1, bus_req=0, inst_valid=0.
  - Halt is level-ignored while HALTED; the only exits are redirect or reset.
- redirect_valid=1 (halt=0, any state including HALTED): pc<=redirect_pc, inst_valid<=0, next state FETCH.
  - A read issued in the previous cycle (state WAIT) is discarded.
  - No bus request is issued in the redirect cycle.
- FETCH:
  - bus_en=1: next state WAIT.
  - bus_grant=0: stay in FETCH, bus_req held high.
- WAIT:
  - mem_data_out holds the word read at the preceding posedge; capture inst<=mem_data_out, inst_pc<=pc, pc<=pc+1 (32-bit, 32'hFFFFFFFF wraps to 0), inst_valid<=1.
  - Next state HOLD.
  - Latency: FETCH with grant in cycle N; inst_valid=1 from cycle N+2.
- HOLD:
  - inst/inst_pc/inst_valid held stable until inst_ready.
  - On inst_valid && inst_ready: inst_valid<=0, fetch_count<=fetch_count+1 (wraps), next state FETCH.
  - If redirect or halt occurs in the same cycle, the handshake still counts (the word was accepted), but the next state follows the redirect/halt rules.
- Outside a valid handshake, inst_ready is ignored.
- Sustained throughput: one instruction per 3 cycles with continuous grant and ready (no overlap).

Test Plan:
- Reset, then zero array words 0..2 = 32'hA, B, C; grant=1, ready=1 → bus offsets 0,1,2 on mode 000; inst/inst_pc = (A,0), (B,1), (C,2); inst_valid first high 2 cycles after reset release; fetch_count=3.
- grant=0 for 4 cycles after reset → bus_req=1, bus_en=0, mode=100 throughout; read issues in the cycle grant rises.
- ready=0 for 5 cycles in HOLD → inst, inst_pc, inst_valid stable; no bus request; fetch_count unchanged until ready=1.
- redirect_valid with redirect_pc=32'h40 during WAIT → returning word discarded, inst_valid stays 0; next read uses offset 32'h40; delivered inst_pc=32'h40.
- halt during FETCH with grant=1 → no read issued; halted=1, inst_valid=0; later redirect_pc=5 → halted=0, fetch at offset 5. Halt+redirect in the same cycle → HALTED.
- redirect_pc=32'hFFFFFFFF → inst_pc=32'hFFFFFFFF, next fetch offset 0. Reset asserted mid-HOLD → inst_valid=0, pc=RESET_PC, fetch_count=0.
